// File: rtl/div_pkg.sv
// div_pkg: shared constants, FSM state type and helpers for the EX-stage divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

  // Reset and data constants reused across the pipeline
  localparam logic        RstEnable  = 1'b1;
  localparam logic        RstDisable = 1'b0;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;

  // Divider handshake levels
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivAnnul          = 1'b1;
  localparam logic DivNoAnnul        = 1'b0;

  // Number of restoring iterations for a 32-bit quotient
  localparam logic [5:0] DivIters = 6'd32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Magnitude of a word when treated as signed; passthrough otherwise.
  // -2^31 maps to 0x80000000, which is its correct unsigned magnitude.
  function automatic logic [31:0] div_abs(input logic is_signed, input logic [31:0] v);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// div: 32-bit radix-2 restoring divider (DIV/DIVU), {remainder, quotient} result.
// Latency: ready_o 34 cycles after start (2 cycles for a zero divisor).
// Backpressure: result held in END while start_i stays high; stallreq_o = start_i & ~ready_o.
//
// Ports:
//   clk, rst        pipeline clock, synchronous active-high reset
//   signed_div_i    1 = signed divide, 0 = unsigned
//   opdata1_i/2_i   dividend / divisor, held stable by EX until ready_o
//   start_i         request, held high until ready_o is seen
//   annul_i         abort an in-flight division
//   result_o        {remainder, quotient}, valid while ready_o = 1
//   ready_o         registered result-valid
//   stallreq_o      EX-side stall request to the pipeline controller
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // [64:33] partial remainder, [32:1] dividend bits still to consume,
  // quotient bits accumulate from [0] upward.
  logic [64:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic        sign1_q, sign1_d;
  logic        sign2_q, sign2_d;
  logic        ready_d;
  logic [63:0] result_d;

  // The window (partial remainder shifted with the next dividend bit) can
  // reach 2*divisor-1, i.e. 33 bits; one extra bit gives an unambiguous
  // borrow for the trial subtraction.
  logic [33:0] tmp;
  assign tmp = {1'b0, dividend_q[64:32]} - {2'b00, divisor_q};

  logic [31:0] quo_fix, rem_fix;

  assign stallreq_o = start_i & ~ready_o;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sign1_d    = sign1_q;
    sign2_d    = sign2_q;
    ready_d    = ready_o;
    result_d   = result_o;
    quo_fix    = dividend_q[31:0];
    rem_fix    = dividend_q[64:33];

    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = {ZeroWord, ZeroWord};
        if (start_i == DivStart && annul_i == DivNoAnnul) begin
          if (opdata2_i == ZeroWord) begin
            state_d = DivByZero;
          end else begin
            state_d    = DivOn;
            cnt_d      = 6'd0;
            sign1_d    = opdata1_i[31];
            sign2_d    = opdata2_i[31];
            dividend_d = {ZeroWord, div_abs(signed_div_i, opdata1_i), 1'b0};
            divisor_d  = div_abs(signed_div_i, opdata2_i);
          end
        end
      end

      DivByZero: begin
        state_d  = DivEnd;
        ready_d  = DivResultReady;
        result_d = {ZeroWord, ZeroWord};
      end

      DivOn: begin
        if (annul_i == DivAnnul) begin
          state_d = DivFree;
          cnt_d   = 6'd0;
        end else if (cnt_q != DivIters) begin
          if (tmp[33]) begin
            dividend_d = {dividend_q[63:0], 1'b0};
          end else begin
            dividend_d = {tmp[31:0], dividend_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          if (signed_div_i && (sign1_q ^ sign2_q)) quo_fix = ~dividend_q[31:0] + 32'd1;
          if (signed_div_i && sign1_q)             rem_fix = ~dividend_q[64:33] + 32'd1;
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end
      end

      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = {ZeroWord, ZeroWord};
        end
      end

      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= DivFree;
      cnt_q      <= 6'd0;
      dividend_q <= '0;
      divisor_q  <= ZeroWord;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      ready_o    <= DivResultNotReady;
      result_o   <= {ZeroWord, ZeroWord};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sign1_q    <= sign1_d;
      sign2_q    <= sign2_d;
      ready_o    <= ready_d;
      result_o   <= result_d;
    end
  end

endmodule

// File: tb/tb_div.sv
// tb_div: self-checking bench for div against an arithmetic reference model.
// Latency: checks 34-cycle (2 for zero divisor) result timing.
// Backpressure: exercises result hold in END and start_i release.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks;
  int errors;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero; zero divisor gives 0.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (!sgn) begin
      uq = a / b;
      ur = a % b;
      return {ur, uq};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge with the DUT in FREE.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int hold, input string tag);
    int  cyc;
    int  stall_bad;
    bit  got;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    cyc       = 0;
    stall_bad = 0;
    got       = 0;
    #1;
    while (!got && cyc < 100) begin
      if (ready_o) got = 1;
      else begin
        if (!stallreq_o) stall_bad++;
        tick();
        cyc++;
      end
    end
    check({tag, "_latency"}, 64'(cyc), (b == 32'd0) ? 64'd2 : 64'd34);
    check({tag, "_stall_hi"}, 64'(stall_bad), 64'd0);
    check({tag, "_result"}, result_o, exp);
    check({tag, "_stall_lo"}, {63'd0, stallreq_o}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      annul_i = 1'($urandom_range(0, 1));
      tick();
      check({tag, "_hold"}, {result_o[63:1], result_o[0] & ready_o}, {exp[63:1], exp[0]});
      check({tag, "_hold_rdy"}, {63'd0, ready_o}, 64'd1);
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    check({tag, "_rdy_drop"}, {63'd0, ready_o}, 64'd0);
    check({tag, "_res_clr"}, result_o, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    logic        sgn;
    logic [31:0] a, b;
    int          mode;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();
    tick();
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_stall", {63'd0, stallreq_o}, 64'd0);
    rst = 1'b0;
    tick();

    // Directed cases
    do_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 0, "u100_7");
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, "s_m7_2");
    do_div(1'b0, 32'hFFFF_FFF9, 32'd2, {32'h1, 32'h7FFF_FFFC}, 0, "u_fff9_2");
    do_div(1'b0, 32'd5, 32'd0, 64'd0, 0, "u5_0");

    // Annul in cycle 10; EX drops the request alongside the flush
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (10) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      if (ready_o) seen = 1;
      tick();
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0, "after_annul");

    // Reset in cycle 20 of a division
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    start_i = 1'b0;
    tick();
    check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    check("rst_mid_result", result_o, 64'd0);
    rst = 1'b0;
    do_div(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 0, "after_rst");

    // Overflow wrap with held result
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 5, "s_min_m1");

    // Randomized against the reference model
    for (int n = 0; n < 40; n++) begin
      sgn  = 1'($urandom_range(0, 1));
      a    = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      mode = int'($urandom_range(0, 7));
      case (mode)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = a;
        4:       b = 32'h8000_0000 | $urandom;
        default: b = $urandom;
      endcase
      do_div(sgn, a, b, ref_div(sgn, a, b), int'($urandom_range(0, 2)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
